mem_port_arbiter: RTL and testbench

- Shares one single-port, handshaked memory between the instruction-fetch requester and the MEM-stage data requester.
- The data requester supplies the memory enables, byte masks, address and store data that the MEM stage passes downstream.
- Sequences each access: grant, hold, wait for ack, return data, signal ready.
- Drives the pipeline stall lines while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshaked single-port memory between the
// instruction-fetch requester and the MEM-stage data requester. Each access
// runs grant -> hold -> ack (or timeout) -> one-cycle ready -> idle.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int FAIR_N   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    input  logic [3:0]        d_rmask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

    localparam logic [7:0] FAIR_MAX  = 8'(FAIR_N);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [7:0]        fair_cnt;
    logic [3:0]        rmask_q;
    logic              wr_q;
    logic              d_pend;
    logic              d_grant;
    logic [DATA_W-1:0] masked_rdata;

    // Arbitration decision and combinational stall lines
    always_comb begin
        d_pend    = d_rd_en | d_wr_en;
        d_grant   = d_pend && (!if_req || (fair_cnt < FAIR_MAX));
        stall_if  = if_req & ~if_ready;
        stall_mem = d_pend & ~d_ready;
    end

    // Zero the byte lanes the load did not ask for (mask latched at grant)
    always_comb begin
        masked_rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            masked_rdata[8*i +: 8] = rmask_q[i] ? mem_rdata[8*i +: 8] : 8'h00;
        end
    end

    // Access sequencer: grant, hold memory controls, wait for ack or timeout, pulse ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            fair_cnt  <= '0;
            rmask_q   <= '0;
            wr_q      <= 1'b0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        state     <= D_ACC;
                        mem_ce    <= 1'b1;
                        mem_addr  <= d_addr;
                        // A simultaneous read+write request is carried out as a write
                        mem_we    <= d_wr_en;
                        mem_wdata <= d_wr_en ? d_wdata : '0;
                        mem_wmask <= d_wr_en ? d_wmask : 4'b0000;
                        wr_q      <= d_wr_en;
                        rmask_q   <= d_rmask;
                        err       <= d_rd_en & d_wr_en;
                        wait_cnt  <= '0;
                        // d_grant with if_req high implies fair_cnt < FAIR_MAX, so no overflow
                        fair_cnt  <= if_req ? fair_cnt + 8'd1 : '0;
                    end else if (if_req) begin
                        state     <= I_ACC;
                        mem_ce    <= 1'b1;
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= 4'b0000;
                        wait_cnt  <= '0;
                        fair_cnt  <= '0;
                    end
                end
                D_ACC, I_ACC: begin
                    if (mem_ack) begin
                        mem_ce <= 1'b0;
                        state  <= DONE;
                        if (state == D_ACC) begin
                            d_rdata <= wr_q ? '0 : masked_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_ce <= 1'b0;
                        state  <= DONE;
                        err    <= 1'b1;
                        if (state == D_ACC) begin
                            d_rdata <= '0;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                // Ready is high for this one cycle; no grant is made here
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder with
// programmable ack latency, a scoreboard of expected completions, and
// directed accesses covering fetch, masked load, store, fairness, timeout,
// illegal request and reset mid-access.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [3:0]  d_rmask;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(15),
        .FAIR_N  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_rd_en  (d_rd_en),
        .d_wr_en  (d_wr_en),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_rmask  (d_rmask),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_ce   (mem_ce),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .err      (err)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          ack_en;
    int          ack_delay;
    logic [31:0] rdata_val;
    int          ce_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: ack ack_delay cycles after mem_ce first seen high
    always @(negedge clk) begin
        if (mem_ce && ack_en) begin
            if (ce_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_val;
            end else begin
                mem_ack = 1'b0;
            end
            ce_cnt++;
        end else begin
            mem_ack = 1'b0;
            ce_cnt  = 0;
        end
    end

    // Scoreboard: every ready pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (!rst && (if_ready || d_ready)) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_ready", 32'(if_ready | d_ready), 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_owner", 32'(d_ready), 32'(e.is_d));
                chk("sb_data", d_ready ? d_rdata : if_rdata, e.data);
            end
        end
    end

    // kind: 0 fetch, 1 read, 2 write, 3 read+write (illegal)
    task automatic access(input string tag, input int kind, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [3:0] rmask, input logic [31:0] mrd, input int dly,
                          input bit ack_on, input logic [31:0] exp_rd,
                          input int exp_ce, input int exp_err);
        logic       exp_we;
        logic [3:0] exp_wm;
        bit         hold_ok;
        bit         rdy;
        int         ce_n;
        int         err_n;
        sb_t        e;
        exp_we  = (kind != 0) && (kind != 1);
        exp_wm  = exp_we ? wmask : 4'b0000;
        hold_ok = 1'b1;
        rdy     = 1'b0;
        ce_n    = 0;
        err_n   = 0;
        e.is_d  = (kind != 0);
        e.data  = exp_rd;
        sb_q.push_back(e);
        rdata_val = mrd;
        ack_delay = dly;
        ack_en    = ack_on;
        if (kind == 0) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_rd_en = (kind == 1) || (kind == 3);
            d_wr_en = (kind == 2) || (kind == 3);
            d_addr  = addr;
            d_wdata = wdata;
            d_wmask = wmask;
            d_rmask = rmask;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_ce) begin
                ce_n++;
                if (mem_addr !== addr || mem_we !== exp_we || mem_wmask !== exp_wm)
                    hold_ok = 1'b0;
                if (exp_we && mem_wdata !== wdata) hold_ok = 1'b0;
                if ((kind == 0 ? stall_if : stall_mem) !== 1'b1) hold_ok = 1'b0;
            end
            if (err) err_n++;
            rdy = (kind == 0) ? if_ready : d_ready;
            if (rdy) break;
        end
        chk({tag, "_ready_seen"}, 32'(rdy), 32'd1);
        if_req  = 1'b0;
        d_rd_en = 1'b0;
        d_wr_en = 1'b0;
        chk({tag, "_ce_cycles"}, 32'(ce_n), 32'(exp_ce));
        chk({tag, "_err_pulses"}, 32'(err_n), 32'(exp_err));
        chk({tag, "_ctrl_held"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        chk({tag, "_stall_after"}, 32'({stall_if, stall_mem}), 32'd0);
        chk({tag, "_ce_after"}, 32'(mem_ce), 32'd0);
    endtask

    initial begin
        int   n_rdy;
        int   n_bad;
        bit   seen;
        sb_t  e;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_rd_en = 1'b0; d_wr_en = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0; d_rmask = '0;
        mem_ack = 1'b0; mem_rdata = '0; ack_en = 1'b0; ack_delay = 0;
        rdata_val = '0; ce_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {26'd0, mem_ce, mem_we, if_ready, d_ready, err, stall_if}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access("fetch", 0, 32'h0000_0040, '0, 4'h0, 4'h0, 32'h2402_0005, 2, 1'b1,
               32'h2402_0005, 3, 0);
        access("ld_mask", 1, 32'h0000_0104, '0, 4'h0, 4'b0011, 32'hDEAD_BEEF, 0, 1'b1,
               32'h0000_BEEF, 1, 0);
        access("ld_hi", 1, 32'h0000_0108, '0, 4'h0, 4'b1100, 32'h1234_5678, 1, 1'b1,
               32'h1234_0000, 2, 0);
        access("st_byte", 2, 32'h0000_0100, 32'h0000_00AB, 4'b0001, 4'h0, 32'hFFFF_FFFF, 1,
               1'b1, 32'h0000_0000, 2, 0);
        access("timeout", 1, 32'h0000_0200, '0, 4'h0, 4'hF, 32'h5555_5555, 0, 1'b0,
               32'h0000_0000, 15, 1);
        access("illegal", 3, 32'h0000_0300, 32'hA5A5_5A5A, 4'b1111, 4'hF, 32'h7777_7777, 0,
               1'b1, 32'h0000_0000, 1, 1);

        // Fairness: both requesters held, immediate ack; owners must go D,D,I,D,D,I
        rdata_val = 32'hCAFE_F00D; ack_delay = 0; ack_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e.is_d = (k % 3) != 2;
            e.data = 32'hCAFE_F00D;
            sb_q.push_back(e);
        end
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_rd_en = 1'b1; d_addr = 32'h0000_0500; d_rmask = 4'hF;
        n_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) n_rdy++;
            if (n_rdy == 6) break;
        end
        if_req = 1'b0; d_rd_en = 1'b0;
        chk("fair_completions", 32'(n_rdy), 32'd6);
        @(negedge clk);

        // Reset while a fetch is outstanding, then re-grant of the held fetch
        e.is_d = 1'b0; e.data = 32'h1111_2222;
        sb_q.push_back(e);
        rdata_val = 32'h1111_2222; ack_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ce) begin seen = 1'b1; break; end
        end
        chk("kill_granted", 32'(seen), 32'd1);
        @(negedge clk);
        n_bad = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("kill_ce_low", 32'(mem_ce), 32'd0);
        if (if_ready || err) n_bad++;
        rst = 1'b0; ack_en = 1'b1; ack_delay = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err) n_bad++;
            if (if_ready) begin seen = 1'b1; break; end
        end
        if_req = 1'b0;
        chk("kill_no_pulse", 32'(n_bad), 32'd0);
        chk("regrant_ready", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
